// File: rtl/jk_pkg.sv
// Shared definitions for the JK bank sequencer: op encodings and FSM states.
package jk_pkg;

  // Op codes are the {j,k} pair applied to every masked cell.
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/jk_cell.sv
// Single JK storage cell with synchronous active-low reset to q = 0.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qn
);

  logic q_q;
  logic q_d;

  // Next value from the classic JK truth table.
  always_comb begin
    q_d = q_q;
    case ({j, k})
      JK_HOLD:   q_d = q_q;
      JK_RESET:  q_d = 1'b0;
      JK_SET:    q_d = 1'b1;
      JK_TOGGLE: q_d = ~q_q;
      default:   q_d = q_q;
    endcase
  end

  // Storage flop; reset clears the cell.
  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= 1'b0;
    else        q_q <= q_d;
  end

  assign q  = q_q;
  // qn is derived from the stored bit, never held separately.
  assign qn = ~q_q;

endmodule

// File: rtl/jk_bank_sequencer.sv
// Command-driven sequencer that applies a JK op to a masked set of cells
// for a programmable number of clock edges, then pulses done.
module jk_bank_sequencer
  import jk_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             apply_en;

  // State register plus command latch and remaining counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= JK_HOLD;
      mask_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mask_q  <= mask_d;
      rem_q   <= rem_d;
    end
  end

  // Next-state logic: accept in IDLE, count down in APPLY, one cycle of DONE.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    mask_d  = mask_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d   = cmd_op;
          mask_d = cmd_mask;
          if (cmd_count != '0) begin
            state_d = APPLY;
            rem_d   = cmd_count;
          end else begin
            // Zero count skips straight to completion without touching cells.
            state_d = DONE;
            rem_d   = '0;
          end
        end
      end
      APPLY: begin
        // Leave on the last application; the <= guard keeps the counter
        // from ever wrapping below zero.
        if (rem_q <= CNT_W'(1)) begin
          state_d = DONE;
          rem_d   = '0;
        end else begin
          rem_d = rem_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        rem_d   = '0;
      end
    endcase
  end

  // Outputs decoded from the current state; ready is also gated by reset.
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    apply_en  = 1'b0;
    case (state_q)
      IDLE:    cmd_ready = rst_n;
      APPLY: begin
        busy     = 1'b1;
        apply_en = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // One JK cell per bit; unmasked cells and non-APPLY states see {j,k} = 00.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      logic cell_j;
      logic cell_k;
      assign cell_j = apply_en & mask_q[gi] & op_q[1];
      assign cell_k = apply_en & mask_q[gi] & op_q[0];

      jk_cell u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .j     (cell_j),
        .k     (cell_k),
        .q     (q[gi]),
        .qn    (qn[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Self-checking bench for jk_bank_sequencer: directed vector table,
// hand-written multi-cycle corner cases and randomized commands against
// a per-edge behavioural model of the JK bank.
module tb_jk_bank_sequencer;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_RESET  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_mask;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic             busy;
  logic             done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [WIDTH-1:0] model_q;

  jk_bank_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_mask  (cmd_mask),
    .cmd_count (cmd_count),
    .q         (q),
    .qn        (qn),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       op;
    logic [WIDTH-1:0] mask;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] exp_q;
  } vec_t;

  vec_t vecs[7];

  // One edge of the bank as seen from the command's point of view.
  function automatic logic [WIDTH-1:0] jk_apply(input logic [WIDTH-1:0] cur,
                                                input logic [1:0] op,
                                                input logic [WIDTH-1:0] mask);
    case (op)
      OP_RESET:  return cur & ~mask;
      OP_SET:    return cur | mask;
      OP_TOGGLE: return cur ^ mask;
      default:   return cur;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_q(input string name);
    logic [WIDTH-1:0] exp_qn;
    exp_qn = ~model_q;
    check({name, ".q"}, 32'(q), 32'(model_q));
    check({name, ".qn"}, 32'(qn), 32'(exp_qn));
  endtask

  // Issue one command and follow it edge by edge until the block is idle again.
  task automatic run_cmd(input logic [1:0] op, input logic [WIDTH-1:0] mask,
                         input logic [CNT_W-1:0] cnt);
    @(negedge clk);
    check("ready_before_issue", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_mask  = mask;
    cmd_count = cnt;
    @(posedge clk);
    #1;
    // Scramble the inputs after acceptance; they must not matter any more.
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_mask  = WIDTH'($urandom);
    cmd_count = CNT_W'($urandom);
    for (int k = 0; k <= int'(cnt); k++) begin
      @(negedge clk);
      check_q("run");
      check("run.done", 32'(done), 32'(k == int'(cnt)));
      check("run.busy", 32'(busy), 32'd1);
      check("run.ready", 32'(cmd_ready), 32'd0);
      if (k < int'(cnt)) model_q = jk_apply(model_q, op, mask);
    end
    @(negedge clk);
    check("end.ready", 32'(cmd_ready), 32'd1);
    check("end.busy", 32'(busy), 32'd0);
    check("end.done", 32'(done), 32'd0);
    check_q("end");
    $display("cmd op=%b mask=%h cnt=%0d -> q=%h (model %h)", op, mask, cnt, q, model_q);
  endtask

  initial begin
    vecs[0] = '{OP_SET,    8'h0F, 4'd1,  8'h0F};
    vecs[1] = '{OP_TOGGLE, 8'h03, 4'd3,  8'h0C};
    vecs[2] = '{OP_RESET,  8'hFF, 4'd0,  8'h0C};
    vecs[3] = '{OP_SET,    8'h00, 4'd5,  8'h0C};
    vecs[4] = '{OP_TOGGLE, 8'hF0, 4'd2,  8'h0C};
    vecs[5] = '{OP_SET,    8'h30, 4'd15, 8'h3C};
    vecs[6] = '{OP_RESET,  8'h0C, 4'd4,  8'h30};

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = OP_HOLD;
    cmd_mask  = '0;
    cmd_count = '0;
    model_q   = '0;

    // Reset held for two edges.
    repeat (2) begin
      @(negedge clk);
      check("rst.ready", 32'(cmd_ready), 32'd0);
      check("rst.done", 32'(done), 32'd0);
      check("rst.busy", 32'(busy), 32'd0);
      check_q("rst");
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst.ready", 32'(cmd_ready), 32'd1);
    check("post_rst.done", 32'(done), 32'd0);
    $display("reset released: q=%h qn=%h ready=%b", q, qn, cmd_ready);

    // Directed vector table.
    for (int i = 0; i < 7; i++) begin
      run_cmd(vecs[i].op, vecs[i].mask, vecs[i].cnt);
      check($sformatf("vec%0d.q", i), 32'(q), 32'(vecs[i].exp_q));
    end

    // Back-pressure: a second command waits through APPLY and DONE.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_SET; cmd_mask = 8'hF0; cmd_count = 4'd3;
    @(posedge clk);
    #1;
    cmd_op = OP_TOGGLE; cmd_mask = 8'h81; cmd_count = 4'd1;
    @(negedge clk);
    check("bp.ready0", 32'(cmd_ready), 32'd0);
    check_q("bp.e0");
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      model_q = jk_apply(model_q, OP_SET, 8'hF0);
      check("bp.ready", 32'(cmd_ready), 32'd0);
      check("bp.done", 32'(done), 32'(k == 3));
      check_q("bp.a");
    end
    @(negedge clk);
    check("bp.idle_ready", 32'(cmd_ready), 32'd1);
    check("bp.idle_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("bp.b_busy", 32'(busy), 32'd1);
    check_q("bp.b0");
    @(negedge clk);
    model_q = jk_apply(model_q, OP_TOGGLE, 8'h81);
    check("bp.b_done", 32'(done), 32'd1);
    check_q("bp.b1");
    @(negedge clk);
    check("bp.b_ready", 32'(cmd_ready), 32'd1);
    check("bp.b_busy_end", 32'(busy), 32'd0);
    $display("back-pressure: q=%h (model %h)", q, model_q);

    // Reset in the middle of a long toggle run.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_TOGGLE; cmd_mask = 8'hFF; cmd_count = 4'd10;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      model_q = jk_apply(model_q, OP_TOGGLE, 8'hFF);
      check_q("mid.apply");
    end
    rst_n = 1'b0;
    #1;
    check("mid.ready_in_rst", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    model_q = '0;
    check_q("mid.rst");
    check("mid.done", 32'(done), 32'd0);
    check("mid.busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    #1;
    check("mid.ready_after", 32'(cmd_ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("mid.no_done", 32'(done), 32'd0);
      check_q("mid.idle");
    end
    $display("reset mid-operation: q=%h done=%b ready=%b", q, done, cmd_ready);

    // Randomized commands against the model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]       r_op;
      logic [WIDTH-1:0] r_mask;
      logic [CNT_W-1:0] r_cnt;
      r_op   = 2'($urandom);
      r_mask = WIDTH'($urandom);
      r_cnt  = CNT_W'($urandom_range(0, 7));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_cmd(r_op, r_mask, r_cnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
